// File: rtl/spike_arbiter.sv
// Merges spike events from NUM_SRC per-source FIFOs onto one shared spike bus.
// Round-robin grant, at most one event per clock, registered bus outputs.
module spike_arbiter #(
   parameter int NUM_SRC    = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [NUM_SRC-1:0]            src_valid,
   output logic [NUM_SRC-1:0]            src_ready,
   input  logic [NUM_SRC*ADDR_WIDTH-1:0] src_address,
   input  logic [NUM_SRC-1:0]            src_on_off,
   output logic                          spike_valid,
   output logic [ADDR_WIDTH-1:0]         spike_address,
   output logic                          spike_on_off,
   output logic [NUM_SRC-1:0]            overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int SW = $clog2(NUM_SRC);
   localparam int EW = ADDR_WIDTH + 1;

   logic [NUM_SRC-1:0]         w_full;
   logic [NUM_SRC-1:0]         w_empty;
   logic [NUM_SRC-1:0]         w_push;
   logic [NUM_SRC-1:0]         w_pop;
   logic [NUM_SRC-1:0][EW-1:0] w_head;

   // One FIFO per source; the extra pointer MSB tells full from empty.
   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fifo
         logic [EW-1:0] r_mem [FIFO_DEPTH];
         logic [PW:0]   r_wptr;
         logic [PW:0]   r_rptr;

         assign w_empty[gi] = (r_wptr == r_rptr);
         assign w_full[gi]  = (r_wptr[PW] != r_rptr[PW]) &&
                              (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
         assign w_push[gi]  = src_valid[gi] & ~w_full[gi];
         assign w_head[gi]  = r_mem[r_rptr[PW-1:0]];

         always_ff @(posedge clk) begin
            if (reset) begin
               r_wptr <= '0;
               r_rptr <= '0;
            end else begin
               if (w_push[gi]) r_wptr <= r_wptr + (PW+1)'(1);
               if (w_pop[gi])  r_rptr <= r_rptr + (PW+1)'(1);
            end
         end

         always_ff @(posedge clk) begin
            if (w_push[gi])
               r_mem[r_wptr[PW-1:0]] <= {src_address[gi*ADDR_WIDTH +: ADDR_WIDTH], src_on_off[gi]};
         end
      end
   endgenerate

   logic [SW-1:0]      r_rr_ptr;
   logic [SW-1:0]      w_cand;
   logic [SW-1:0]      w_win_idx;
   logic [SW-1:0]      w_next_ptr;
   logic               w_found;
   logic               w_grant;
   logic [EW-1:0]      w_win_data;
   logic               r_spike_valid;
   logic [ADDR_WIDTH-1:0] r_spike_address;
   logic               r_spike_on_off;
   logic [NUM_SRC-1:0] r_overflow;

   // First non-empty FIFO at or after the round-robin pointer, wrapping.
   always_comb begin
      w_found    = 1'b0;
      w_win_idx  = '0;
      w_win_data = '0;
      w_cand     = '0;
      w_pop      = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         w_cand = SW'((int'(r_rr_ptr) + k) % NUM_SRC);
         if (!w_found && !w_empty[w_cand]) begin
            w_found    = 1'b1;
            w_win_idx  = w_cand;
            w_win_data = w_head[w_cand];
         end
      end
      w_grant = w_found & enable;
      if (w_grant) w_pop[w_win_idx] = 1'b1;
      w_next_ptr = (w_win_idx == SW'(NUM_SRC - 1)) ? '0 : w_win_idx + SW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_spike_valid   <= 1'b0;
         r_spike_address <= '0;
         r_spike_on_off  <= 1'b0;
         r_rr_ptr        <= '0;
         r_overflow      <= '0;
      end else begin
         r_overflow <= r_overflow | (src_valid & w_full);
         if (w_grant) begin
            r_spike_valid   <= 1'b1;
            r_spike_address <= w_win_data[EW-1:1];
            r_spike_on_off  <= w_win_data[0];
            r_rr_ptr        <= w_next_ptr;
         end else begin
            r_spike_valid <= 1'b0;
         end
      end
   end

   assign src_ready     = ~w_full;
   assign spike_valid   = r_spike_valid;
   assign spike_address = r_spike_address;
   assign spike_on_off  = r_spike_on_off;
   assign overflow      = r_overflow;

endmodule

// File: tb/tb_spike_arbiter.sv
// Directed bench for spike_arbiter: expected bus events go into a queue,
// a negedge monitor pops and compares each issued event.
module tb_spike_arbiter;

   localparam int NS = 4;
   localparam int AW = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic            enable;
   logic [NS-1:0]   src_valid;
   logic [NS-1:0]   src_ready;
   logic [NS*AW-1:0] src_address;
   logic [NS-1:0]   src_on_off;
   logic            spike_valid;
   logic [AW-1:0]   spike_address;
   logic            spike_on_off;
   logic [NS-1:0]   overflow;

   logic [AW:0] exp_q [$];
   logic [AW:0] mon_e;
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   spike_arbiter #(.NUM_SRC(NS), .ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .src_valid     (src_valid),
      .src_ready     (src_ready),
      .src_address   (src_address),
      .src_on_off    (src_on_off),
      .spike_valid   (spike_valid),
      .spike_address (spike_address),
      .spike_on_off  (spike_on_off),
      .overflow      (overflow)
   );

   // Scoreboard monitor: every issued bus event must match the queue head.
   always @(negedge clk) begin
      if (spike_valid === 1'b1) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL bus_event: got addr=%h on=%b, required no event", spike_address, spike_on_off);
         end else begin
            mon_e = exp_q.pop_front();
            if ({spike_address, spike_on_off} !== mon_e) begin
               n_err++;
               $display("FAIL bus_event: got addr=%h on=%b, required addr=%h on=%b",
                        spike_address, spike_on_off, mon_e[AW:1], mon_e[0]);
            end else begin
               $display("bus addr=%h on=%b", spike_address, spike_on_off);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc_check(input string name, input logic req);
      @(negedge clk);
      check(name, 32'(spike_valid), 32'(req));
      step();
   endtask

   task automatic set_src(input int i, input logic [AW-1:0] a, input logic on);
      src_valid[i]            = 1'b1;
      src_address[i*AW +: AW] = a;
      src_on_off[i]           = on;
   endtask

   task automatic expect_ev(input logic [AW-1:0] a, input logic on);
      exp_q.push_back({a, on});
   endtask

   task automatic drain(input string name);
      int i = 0;
      while (exp_q.size() != 0 && i < 40) begin
         @(negedge clk);
         i++;
      end
      step();
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset       = 1'b1;
      enable      = 1'b1;
      src_valid   = '0;
      src_address = '0;
      src_on_off  = '0;
      repeat (3) step();
      reset = 1'b0;
      @(negedge clk);
      check("rst_valid", 32'(spike_valid), 32'd0);
      check("rst_addr", 32'(spike_address), 32'd0);
      check("rst_onoff", 32'(spike_on_off), 32'd0);
      check("rst_ready", 32'(src_ready), 32'hF);
      check("rst_overflow", 32'(overflow), 32'h0);
      step();

      // Single event: visible after the second edge, for one cycle only.
      set_src(0, 8'h05, 1'b1);
      expect_ev(8'h05, 1'b1);
      step();
      src_valid = '0;
      cyc_check("single_lat_t", 1'b0);
      cyc_check("single_lat_t1", 1'b1);
      cyc_check("single_pulse_end", 1'b0);

      // Reset with three queued events held back by enable=0.
      enable = 1'b0;
      set_src(0, 8'h70, 1'b1);
      set_src(1, 8'h71, 1'b0);
      set_src(2, 8'h72, 1'b1);
      step();
      src_valid = '0;
      reset = 1'b1;
      step();
      reset  = 1'b0;
      enable = 1'b1;
      @(negedge clk);
      check("midrst_valid", 32'(spike_valid), 32'd0);
      check("midrst_ready", 32'(src_ready), 32'hF);
      step();
      repeat (6) step();
      check("midrst_overflow", 32'(overflow), 32'h0);

      // All four sources at once: issued 10..13 on consecutive cycles.
      for (int i = 0; i < NS; i++) begin
         set_src(i, 8'(8'h10 + i), 1'(i + 1));
         expect_ev(8'(8'h10 + i), 1'(i + 1));
      end
      step();
      src_valid = '0;
      cyc_check("rr_t", 1'b0);
      for (int i = 0; i < NS; i++) cyc_check("rr_burst", 1'b1);
      cyc_check("rr_end", 1'b0);
      step();

      // src2 streams 20..27 while src0 slips in one event at the third edge.
      expect_ev(8'h20, 1'b0);
      expect_ev(8'h21, 1'b1);
      expect_ev(8'h40, 1'b1);
      for (int k = 2; k < 8; k++) expect_ev(8'(8'h20 + k), 1'(k));
      for (int k = 0; k < 8; k++) begin
         src_valid = '0;
         set_src(2, 8'(8'h20 + k), 1'(k));
         if (k == 2) set_src(0, 8'h40, 1'b1);
         step();
      end
      src_valid = '0;
      drain("fair_drain");

      // Fill src1 with issue held, then probe backpressure and overflow.
      enable = 1'b0;
      for (int k = 0; k < 4; k++) begin
         src_valid = '0;
         set_src(1, 8'(8'h50 + k), 1'(k));
         expect_ev(8'(8'h50 + k), 1'(k));
         step();
      end
      src_valid = '0;
      @(negedge clk);
      check("full_ready", 32'(src_ready), 32'hD);
      check("full_no_overflow", 32'(overflow), 32'h0);
      step();
      set_src(1, 8'h99, 1'b1);
      step();
      src_valid = '0;
      @(negedge clk);
      check("full_overflow", 32'(overflow), 32'h2);
      check("full_ready_hold", 32'(src_ready), 32'hD);
      check("full_hold_valid", 32'(spike_valid), 32'd0);
      step();
      enable = 1'b1;
      drain("full_drain");
      check("drained_ready", 32'(src_ready), 32'hF);
      for (int k = 0; k < 6; k++) begin
         src_valid = '0;
         set_src(1, 8'(8'h60 + k), 1'(k + 1));
         expect_ev(8'(8'h60 + k), 1'(k + 1));
         step();
      end
      src_valid = '0;
      drain("wrap_drain");
      check("overflow_sticky", 32'(overflow), 32'h2);

      // Same address from two sources stays two events; then on followed by off.
      expect_ev(8'h2A, 1'b1);
      expect_ev(8'h2A, 1'b1);
      expect_ev(8'h2A, 1'b0);
      set_src(0, 8'h2A, 1'b1);
      set_src(3, 8'h2A, 1'b1);
      step();
      src_valid = '0;
      set_src(3, 8'h2A, 1'b0);
      step();
      src_valid = '0;
      drain("onoff_drain");
      repeat (4) step();
      check("final_queue", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
